// File: rtl/chain_mult_pkg.sv
// Shared types and sizing for the bit-serial triple-operand multiplier.
`timescale 1ns/1ps
package chain_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Three WIDTH-bit factors never need more than 3*WIDTH bits.
  function automatic int product_width(input int w);
    return 3 * w;
  endfunction

endpackage

// File: rtl/chain_mult_shift_add_step.sv
// One shift-add multiply step: conditionally add the multiplicand to the accumulator.
`timescale 1ns/1ps
module shift_add_step #(
  parameter int W = 24
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] mcand,
  input  logic         lsb,
  output logic [W-1:0] acc_next
);

  assign acc_next = lsb ? (acc + mcand) : acc;

endmodule

// File: rtl/chain_mult.sv
// Sequential I*J*K multiplier: two WIDTH-cycle shift-add passes sharing one adder step.
`timescale 1ns/1ps
module chain_mult
  import chain_mult_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int PWIDTH = product_width(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  op_i,
  input  logic [WIDTH-1:0]  op_j,
  input  logic [WIDTH-1:0]  op_k,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PWIDTH-1:0] product,
  output logic              busy
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t            state_reg, state_next;
  logic [PWIDTH-1:0] acc_reg;
  logic [PWIDTH-1:0] mcand_reg;
  logic [PWIDTH-1:0] product_reg;
  logic [PWIDTH-1:0] acc_step;
  logic [WIDTH-1:0]  mplier_reg;
  logic [WIDTH-1:0]  k_reg;
  logic [CW-1:0]     cnt_reg;
  logic              last_bit;

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  shift_add_step #(.W(PWIDTH)) u_step (
    .acc      (acc_reg),
    .mcand    (mcand_reg),
    .lsb      (mplier_reg[0]),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid)  state_next = MUL1;
      MUL1: if (last_bit)  state_next = MUL2;
      MUL2: if (last_bit)  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg     <= '0;
      mcand_reg   <= '0;
      product_reg <= '0;
      mplier_reg  <= '0;
      k_reg       <= '0;
      cnt_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mcand_reg  <= PWIDTH'(op_i);
            mplier_reg <= op_j;
            k_reg      <= op_k;
            acc_reg    <= '0;
            cnt_reg    <= '0;
          end
        end
        MUL1, MUL2: begin
          if (last_bit) begin
            // End of pass 1 feeds P1 back as the multiplicand; end of pass 2 publishes.
            if (state_reg == MUL1) begin
              mcand_reg  <= acc_step;
              mplier_reg <= k_reg;
            end else begin
              product_reg <= acc_step;
            end
            acc_reg <= '0;
            cnt_reg <= '0;
          end else begin
            acc_reg    <= acc_step;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == MUL1) || (state_reg == MUL2);
  assign product   = product_reg;

endmodule
